// File: rtl/shift_pkg.sv
// Shared encodings for the multi-cycle shift engine: operation codes and FSM states.
package shift_pkg;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_step.sv
// One combinational shift stage: moves the operand by k bits (k <= STEP) for the selected op.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int STEP  = 4,
    localparam int KW   = $clog2(STEP) + 1
)
(
    input  logic [WIDTH-1:0] data,
    input  logic [1:0]       op,
    input  logic [KW-1:0]    k,
    output logic [WIDTH-1:0] result
);

    logic [2*WIDTH-1:0] doubled;

    // Rotating a doubled copy and keeping the upper half gives ROL without a WIDTH-k term.
    always_comb begin
        doubled = {data, data} << k;
        case (op)
            OP_SLL:  result = data << k;
            OP_SRL:  result = data >> k;
            OP_SRA:  result = $signed(data) >>> k;
            default: result = doubled[2*WIDTH-1:WIDTH];
        endcase
    end

endmodule

// File: rtl/shift_unit_seq.sv
// Multi-cycle shifter with valid/ready handshakes; each SHIFT cycle moves the data by up to STEP bits.
module shift_unit_seq
    import shift_pkg::*;
#(
    parameter int WIDTH    = 64,
    parameter int STEP     = 4,
    localparam int SHAMT_W = $clog2(WIDTH)
)
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         op,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   din,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   dout
);

    localparam int KW = $clog2(STEP) + 1;
    // When STEP == WIDTH the clamp is WIDTH-1, which already covers every legal remaining count.
    localparam logic [SHAMT_W-1:0] STEP_S = (STEP >= WIDTH) ? {SHAMT_W{1'b1}} : SHAMT_W'(STEP);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic [1:0]           op_q, op_d;
    logic [SHAMT_W-1:0]   rem_q, rem_d;
    logic [SHAMT_W-1:0]   k_s;
    logic [KW-1:0]        k;
    logic [WIDTH-1:0]     step_out;

    assign k_s = (rem_q > STEP_S) ? STEP_S : rem_q;
    assign k   = KW'(k_s);

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .data   (data_q),
        .op     (op_q),
        .k      (k),
        .result (step_out)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            op_q    <= OP_SLL;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            op_q    <= op_d;
            rem_q   <= rem_d;
        end
    end

    // flush wins over both accept and out_ready, so it is decoded ahead of the state case.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        op_d    = op_q;
        rem_d   = rem_q;
        if (flush) begin
            state_d = S_IDLE;
            rem_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        data_d  = din;
                        op_d    = op;
                        rem_d   = shamt;
                        state_d = (shamt == '0) ? S_DONE : S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    data_d = step_out;
                    rem_d  = rem_q - k_s;
                    if (rem_q == k_s) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign dout      = data_q;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed bench for shift_unit_seq: vector table for op/latency checks plus handshake, flush and reset sequences.
module tb_shift_unit_seq;
    import shift_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [5:0]  shamt;
    logic [63:0] din;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] dout;

    int vectors;
    int miscompares;

    typedef struct {
        logic [1:0]  op;
        logic [5:0]  shamt;
        logic [63:0] din;
        logic [63:0] exp_dout;
        int          exp_lat;
    } vec_t;

    vec_t vecs[12];

    shift_unit_seq #(
        .WIDTH (64),
        .STEP  (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .shamt     (shamt),
        .din       (din),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Presents one operand for a single accept edge; returns #1 after that edge.
    task automatic applyStimulus(input logic [1:0] o, input logic [5:0] s, input logic [63:0] d);
        @(negedge clk);
        in_valid = 1'b1;
        op       = o;
        shamt    = s;
        din      = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Latency counts the cycle right after the accept edge as 1; bounded so a stuck DUT still ends.
    task automatic waitResult(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int pulses;

        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        in_valid    = 1'b0;
        op          = OP_SLL;
        shamt       = '0;
        din         = '0;
        flush       = 1'b0;
        out_ready   = 1'b1;

        vecs[0]  = '{OP_SLL, 6'd2,  64'h0000_0000_0000_0001, 64'h0000_0000_0000_0004, 2};
        vecs[1]  = '{OP_SRA, 6'd63, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 17};
        vecs[2]  = '{OP_SRL, 6'd63, 64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001, 17};
        vecs[3]  = '{OP_ROL, 6'd4,  64'h8000_0000_0000_0001, 64'h0000_0000_0000_0018, 2};
        vecs[4]  = '{OP_SLL, 6'd0,  64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 1};
        vecs[5]  = '{OP_SRA, 6'd5,  64'h7000_0000_0000_0000, 64'h0380_0000_0000_0000, 3};
        vecs[6]  = '{OP_SLL, 6'd63, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 17};
        vecs[7]  = '{OP_ROL, 6'd8,  64'h0123_4567_89AB_CDEF, 64'h2345_6789_ABCD_EF01, 3};
        vecs[8]  = '{OP_SRA, 6'd7,  64'hF000_0000_0000_0000, 64'hFFE0_0000_0000_0000, 3};
        vecs[9]  = '{OP_SRL, 6'd1,  64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 2};
        vecs[10] = '{OP_ROL, 6'd63, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 17};
        vecs[11] = '{OP_SRL, 6'd32, 64'hDEAD_BEEF_0123_4567, 64'h0000_0000_DEAD_BEEF, 9};

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("reset_dout", dout, 64'd0);
        checkOutput("reset_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].op, vecs[i].shamt, vecs[i].din);
            waitResult(lat);
            checkOutput($sformatf("vec%0d_dout", i), dout, vecs[i].exp_dout);
            checkOutput($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d_in_ready_after", i), {63'd0, in_ready}, 64'd1);
        end

        // Backpressure: result must hold, and an operand offered alongside the accept is refused.
        out_ready = 1'b0;
        applyStimulus(OP_SLL, 6'd2, 64'h1);
        waitResult(lat);
        checkOutput("bp_latency", 64'(lat), 64'd2);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            checkOutput("bp_out_valid", {63'd0, out_valid}, 64'd1);
            checkOutput("bp_dout", dout, 64'h4);
            checkOutput("bp_in_ready", {63'd0, in_ready}, 64'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        op        = OP_SLL;
        shamt     = 6'd2;
        din       = 64'h5;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("bp_release_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("bp_release_in_ready", {63'd0, in_ready}, 64'd1);

        // Flush mid-SHIFT, with a competing operand that must not be taken.
        applyStimulus(OP_SRL, 6'd63, 64'h8000_0000_0000_0000);
        @(posedge clk);
        #1;
        checkOutput("flush_busy_in_ready", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        shamt    = 6'd5;
        din      = 64'h1234;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        checkOutput("flush_in_ready", {63'd0, in_ready}, 64'd1);
        checkOutput("flush_out_valid", {63'd0, out_valid}, 64'd0);
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) pulses++;
        end
        checkOutput("flush_no_result", 64'(pulses), 64'd0);

        // Asynchronous reset mid-SHIFT, then a fresh branch-target shift.
        applyStimulus(OP_SRA, 6'd63, 64'h8000_0000_0000_0000);
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        checkOutput("rst_mid_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("rst_mid_dout", dout, 64'd0);
        checkOutput("rst_mid_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(OP_SLL, 6'd2, 64'h1);
        waitResult(lat);
        checkOutput("post_rst_dout", dout, 64'h4);
        checkOutput("post_rst_latency", 64'(lat), 64'd2);
        @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
